// File: rtl/booth_div.sv
// Sequential signed divider: radix-2 restoring division on operand magnitudes,
// one quotient bit per clock, en/done handshake shared with booth_mult.
module booth_div #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    output logic             done,
    output logic [width-1:0] Q,
    output logic [width-1:0] R,
    output logic             div_by_zero,
    output logic             ovf
);

    typedef enum logic [1:0] {IDLE, CALC, FINISH, HOLD} state_t;

    localparam int CW = $clog2(width) + 1;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [width-1:0] quo, rem, a_lat;
    logic [width:0]   dvs;
    logic             qsign, rsign, dz_lat, ovf_lat;
    logic [width:0]   rem_sh, diff;
    logic [width-1:0] a_mag, b_mag;
    logic             last;

    // Magnitudes read as unsigned: -2^(width-1) negates to itself, which is the correct magnitude
    always_comb begin
        a_mag  = A[width-1] ? -A : A;
        b_mag  = B[width-1] ? -B : B;
        rem_sh = {rem, quo[width-1]};
        diff   = rem_sh - dvs;
        last   = (cnt == CW'(width - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (en)   state_nx = CALC;
            CALC:    if (last) state_nx = FINISH;
            FINISH:  state_nx = HOLD;
            HOLD:    if (!en)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            quo         <= '0;
            rem         <= '0;
            dvs         <= '0;
            a_lat       <= '0;
            qsign       <= 1'b0;
            rsign       <= 1'b0;
            dz_lat      <= 1'b0;
            ovf_lat     <= 1'b0;
            done        <= 1'b0;
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        quo     <= a_mag;
                        rem     <= '0;
                        dvs     <= {1'b0, b_mag};
                        a_lat   <= A;
                        qsign   <= A[width-1] ^ B[width-1];
                        rsign   <= A[width-1];
                        dz_lat  <= (B == '0);
                        ovf_lat <= (A == {1'b1, {(width-1){1'b0}}}) && (B == '1);
                        cnt     <= '0;
                    end
                end
                CALC: begin
                    cnt <= cnt + CW'(1);
                    if (!diff[width]) begin
                        rem <= diff[width-1:0];
                        quo <= {quo[width-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh[width-1:0];
                        quo <= {quo[width-2:0], 1'b0};
                    end
                end
                FINISH: begin
                    done        <= 1'b1;
                    div_by_zero <= dz_lat;
                    ovf         <= ovf_lat;
                    if (dz_lat) begin
                        Q <= '1;
                        R <= a_lat;
                    end else begin
                        Q <= qsign ? -quo : quo;
                        R <= rsign ? -rem : rem;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_div.sv
// Scoreboard bench for booth_div (width=8): expected results are queued at
// stimulus time and compared when done pulses.
module tb_booth_div;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [W-1:0] A, B;
    logic         done;
    logic [W-1:0] Q, R;
    logic         div_by_zero, ovf;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   pulses = 0;

    booth_div #(.width(W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .A(A), .B(B),
        .done(done), .Q(Q), .R(R), .div_by_zero(div_by_zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t e;
        int   a, b, q, r;
        a = int'($signed(av));
        b = int'($signed(bv));
        if (b == 0) begin
            e.q  = '1;
            e.r  = av;
            e.dz = 1'b1;
            e.ov = 1'b0;
        end else begin
            q    = a / b;
            r    = a % b;
            e.q  = q[W-1:0];
            e.r  = r[W-1:0];
            e.dz = 1'b0;
            e.ov = (a == -128) && (b == -1);
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            pulses++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("Q", 32'(Q), 32'(e.q));
                check("R", 32'(R), 32'(e.r));
                check("div_by_zero", 32'(div_by_zero), 32'(e.dz));
                check("ovf", 32'(ovf), 32'(e.ov));
            end
        end
    end

    // Drives one operation; optionally holds en after done and scrambles A/B mid-CALC.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input int hold, input bit scramble, input bit chk_lat);
        int cycles = 0;
        sb.push_back(model(av, bv));
        A  = av;
        B  = bv;
        en = 1'b1;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (done) break;
            if (scramble && cycles == 3) begin
                A = ~av;
                B = bv + 8'd3;
            end
            if (cycles > 40) begin
                check("timeout", 32'(cycles), 32'd9);
                break;
            end
            @(posedge clk);
            cycles++;
        end
        if (chk_lat) check("latency", 32'(cycles), 32'd9);
        repeat (hold) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int p0;
        rst_n = 1'b0;
        en    = 1'b0;
        A     = '0;
        B     = '0;
        repeat (2) @(negedge clk);
        check("rst_done", 32'(done), 32'd0);
        check("rst_Q", 32'(Q), 32'd0);
        check("rst_R", 32'(R), 32'd0);
        check("rst_flags", 32'({div_by_zero, ovf}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'd100, 8'd7, 0, 1'b0, 1'b1);
        run_op(-8'sd100, 8'd7, 0, 1'b0, 1'b0);
        run_op(8'd100, -8'sd7, 0, 1'b0, 1'b0);
        run_op(-8'sd100, -8'sd7, 0, 1'b0, 1'b0);
        run_op(8'h80, 8'hFF, 0, 1'b0, 1'b0);
        run_op(8'h80, 8'd1, 0, 1'b0, 1'b0);
        run_op(8'h80, 8'd127, 0, 1'b0, 1'b0);
        run_op(8'd5, 8'd0, 0, 1'b0, 1'b1);
        run_op(8'd0, -8'sd5, 0, 1'b0, 1'b0);

        p0 = pulses;
        run_op(8'd100, 8'd7, 20, 1'b0, 1'b0);
        check("single_pulse", 32'(pulses - p0), 32'd1);
        run_op(8'd127, 8'd127, 0, 1'b0, 1'b0);
        run_op(8'd77, 8'd6, 0, 1'b1, 1'b0);

        // Reset during CALC: in-flight operation must vanish without a done pulse
        p0 = pulses;
        A  = 8'd50;
        B  = 8'd3;
        en = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_Q", 32'(Q), 32'd0);
        check("midrst_R", 32'(R), 32'd0);
        check("midrst_flags", 32'({div_by_zero, ovf}), 32'd0);
        repeat (3) @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("midrst_no_pulse", 32'(pulses - p0), 32'd0);
        run_op(-8'sd7, 8'd2, 0, 1'b0, 1'b0);

        for (int i = 0; i < 2000; i++)
            run_op(W'($urandom), W'($urandom), 0, 1'b0, 1'b0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
